// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states,
// opcodes and the datapath mux-select codes.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH      = 4'd0,
      ST_DECODE     = 4'd1,
      ST_MEM_ADDR   = 4'd2,
      ST_MEM_READ   = 4'd3,
      ST_MEM_WB     = 4'd4,
      ST_MEM_WRITE  = 4'd5,
      ST_EXECUTE    = 4'd6,
      ST_R_COMPLETE = 4'd7,
      ST_BRANCH     = 4'd8,
      ST_JUMP       = 4'd9,
      ST_ADDI_EXEC  = 4'd10,
      ST_ADDI_WB    = 4'd11
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_R)  || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode for the multi-cycle control FSM: state (plus the
// FETCH/MEM_WRITE memory handshake) to datapath strobes and selects.
module mc_output_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [3:0] State,
   input  logic       Mem_Ready,
   input  logic       RST,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       Instr_Done
);

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = PCSRC_ALU;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      Instr_Done  = 1'b0;

      // Holding reset silences every strobe so an aborted instruction writes nothing.
      if (RST) begin
         case (state_e'(State))
            ST_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = Mem_Ready;
               PCWrite = Mem_Ready;
            end
            ST_DECODE: begin
               ALUSrcB = SRCB_IMM_SH2;
            end
            ST_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            ST_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            ST_MEM_WB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               Instr_Done = 1'b1;
            end
            ST_MEM_WRITE: begin
               MemWrite   = 1'b1;
               IorD       = 1'b1;
               Instr_Done = Mem_Ready;
            end
            ST_EXECUTE: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
            end
            ST_R_COMPLETE: begin
               RegWrite   = 1'b1;
               RegDst     = 1'b1;
               Instr_Done = 1'b1;
            end
            ST_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
               Instr_Done  = 1'b1;
            end
            ST_JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = PCSRC_JUMP;
               Instr_Done = 1'b1;
            end
            ST_ADDI_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            ST_ADDI_WB: begin
               // Last cycle of ADDI, so it retires like the other write-back states.
               RegWrite   = 1'b1;
               Instr_Done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for a multi-cycle MIPS datapath: state register,
// opcode-driven sequencing, retired-instruction counter and illegal-op flag.
module multicycle_control
   import multicycle_ctrl_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [5:0]         OP_Code,
   input  logic               Mem_Ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic [1:0]         PCSource,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [3:0]         State,
   output logic               Instr_Done,
   output logic               Illegal_Op,
   output logic [COUNT_W-1:0] Instr_Count
);

   state_e state;
   state_e next_state;
   logic   decode_illegal;

   assign State          = state;
   assign decode_illegal = (state == ST_DECODE) && !is_legal_op(OP_Code);

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!RST) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = ST_FETCH;
      case (state)
         ST_FETCH:     next_state = Mem_Ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (OP_Code)
               OP_LW, OP_SW: next_state = ST_MEM_ADDR;
               OP_R:         next_state = ST_EXECUTE;
               OP_BEQ:       next_state = ST_BRANCH;
               OP_J:         next_state = ST_JUMP;
               OP_ADDI:      next_state = ST_ADDI_EXEC;
               default:      next_state = ST_FETCH;
            endcase
         end
         // IR is not reloaded after FETCH, so OP_Code still names this instruction.
         ST_MEM_ADDR:  next_state = (OP_Code == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  next_state = Mem_Ready ? ST_MEM_WB : ST_MEM_READ;
         ST_MEM_WRITE: next_state = Mem_Ready ? ST_FETCH : ST_MEM_WRITE;
         ST_EXECUTE:   next_state = ST_R_COMPLETE;
         ST_ADDI_EXEC: next_state = ST_ADDI_WB;
         default:      next_state = ST_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         Instr_Count <= '0;
         Illegal_Op  <= 1'b0;
      end else begin
         if (Instr_Done) begin
            Instr_Count <= Instr_Count + COUNT_W'(1);
         end
         if (decode_illegal) begin
            Illegal_Op <= 1'b1;
         end
      end
   end

   mc_output_decode u_output_decode (
      .State       (state),
      .Mem_Ready   (Mem_Ready),
      .RST         (RST),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .PCSource    (PCSource),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .Instr_Done  (Instr_Done)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instructions are expanded into
// expected state walks, each cycle's expectation is queued and checked at negedge.
module tb_multicycle_control;

   localparam int CW = 4;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MREAD = 4'd3,
                          S_MWB = 4'd4, S_MWRITE = 4'd5, S_EXEC = 4'd6, S_RDONE = 4'd7,
                          S_BRANCH = 4'd8, S_JUMP = 4'd9, S_AEXEC = 4'd10, S_AWB = 4'd11;

   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                          O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000;

   logic          CLK = 1'b0;
   logic          RST;
   logic [5:0]    OP_Code;
   logic          Mem_Ready;
   logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic          MemtoReg, RegDst, RegWrite, ALUSrcA, Instr_Done, Illegal_Op;
   logic [1:0]    PCSource, ALUSrcB, ALUOp;
   logic [3:0]    State;
   logic [CW-1:0] Instr_Count;

   multicycle_control #(.COUNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .OP_Code(OP_Code), .Mem_Ready(Mem_Ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .State(State), .Instr_Done(Instr_Done), .Illegal_Op(Illegal_Op),
      .Instr_Count(Instr_Count)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] st;
      logic pcw, pcwc;
      logic [1:0] pcs;
      logic iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop;
      logic done, ill;
      logic [3:0] cnt;
   } exp_t;

   typedef struct packed {
      logic [3:0] s;
      logic       mr;
   } ph_t;

   exp_t sb[$];
   ph_t  plan[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   m_cnt = 0;
   logic m_ill = 1'b0;

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {O_R, O_LW, O_SW, O_BEQ, O_J, O_ADDI};
   endfunction

   // Control table for one cycle in state s with Mem_Ready = mr, reset released.
   function automatic exp_t spec_ctrl(input logic [3:0] s, input logic mr);
      exp_t e;
      e = '0;
      case (s)
         S_FETCH:  begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
         S_DECODE: e.asb = 2'b11;
         S_MADDR:  begin e.asa = 1; e.asb = 2'b10; end
         S_MREAD:  begin e.mrd = 1; e.iord = 1; end
         S_MWB:    begin e.rw = 1; e.m2r = 1; e.done = 1; end
         S_MWRITE: begin e.mwr = 1; e.iord = 1; e.done = mr; end
         S_EXEC:   begin e.asa = 1; e.aop = 2'b10; end
         S_RDONE:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
         S_BRANCH: begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
         S_JUMP:   begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
         S_AEXEC:  begin e.asa = 1; e.asb = 2'b10; end
         S_AWB:    begin e.rw = 1; e.done = 1; end
         default:  ;
      endcase
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // One clock of stimulus: drive inputs, queue the expectation, advance the model.
   task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] s);
      exp_t e;
      RST = r; OP_Code = op; Mem_Ready = mr;
      e = r ? spec_ctrl(s, mr) : '0;
      e.st  = s;
      e.ill = m_ill;
      e.cnt = 4'(m_cnt % 16);
      sb.push_back(e);
      @(posedge CLK); #1;
      if (!r) begin
         m_cnt = 0;
         m_ill = 1'b0;
      end else if (e.done) begin
         m_cnt++;
      end
   endtask

   task automatic build(input logic [5:0] op, input int fs, input int ms);
      plan.delete();
      repeat (fs) plan.push_back('{S_FETCH, 1'b0});
      plan.push_back('{S_FETCH, 1'b1});
      plan.push_back('{S_DECODE, 1'($urandom)});
      case (op)
         O_LW: begin
            plan.push_back('{S_MADDR, 1'($urandom)});
            repeat (ms) plan.push_back('{S_MREAD, 1'b0});
            plan.push_back('{S_MREAD, 1'b1});
            plan.push_back('{S_MWB, 1'($urandom)});
         end
         O_SW: begin
            plan.push_back('{S_MADDR, 1'($urandom)});
            repeat (ms) plan.push_back('{S_MWRITE, 1'b0});
            plan.push_back('{S_MWRITE, 1'b1});
         end
         O_R:    begin plan.push_back('{S_EXEC, 1'($urandom)}); plan.push_back('{S_RDONE, 1'($urandom)}); end
         O_BEQ:  plan.push_back('{S_BRANCH, 1'($urandom)});
         O_J:    plan.push_back('{S_JUMP, 1'($urandom)});
         O_ADDI: begin plan.push_back('{S_AEXEC, 1'($urandom)}); plan.push_back('{S_AWB, 1'($urandom)}); end
         default: ;
      endcase
   endtask

   // Walk the planned states; at index abort_at assert reset instead and stop.
   task automatic play(input logic [5:0] op, input int abort_at);
      for (int i = 0; i < plan.size(); i++) begin
         if (i == abort_at) begin
            step(1'b0, op, 1'($urandom), plan[i].s);
            repeat ($urandom_range(0, 2)) step(1'b0, op, 1'($urandom), S_FETCH);
            return;
         end
         // IR still holds the previous instruction while fetching.
         step(1'b1, (plan[i].s == S_FETCH) ? 6'($urandom) : op, plan[i].mr, plan[i].s);
         if (plan[i].s == S_DECODE && !is_legal(op)) m_ill = 1'b1;
      end
   endtask

   task automatic run(input logic [5:0] op, input int fs, input int ms);
      build(op, fs, ms);
      play(op, -1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("State",       32'(State),       32'(e.st));
            check("PCWrite",     32'(PCWrite),     32'(e.pcw));
            check("PCWriteCond", 32'(PCWriteCond), 32'(e.pcwc));
            check("PCSource",    32'(PCSource),    32'(e.pcs));
            check("IorD",        32'(IorD),        32'(e.iord));
            check("MemRead",     32'(MemRead),     32'(e.mrd));
            check("MemWrite",    32'(MemWrite),    32'(e.mwr));
            check("IRWrite",     32'(IRWrite),     32'(e.irw));
            check("MemtoReg",    32'(MemtoReg),    32'(e.m2r));
            check("RegDst",      32'(RegDst),      32'(e.rdst));
            check("RegWrite",    32'(RegWrite),    32'(e.rw));
            check("ALUSrcA",     32'(ALUSrcA),     32'(e.asa));
            check("ALUSrcB",     32'(ALUSrcB),     32'(e.asb));
            check("ALUOp",       32'(ALUOp),       32'(e.aop));
            check("Instr_Done",  32'(Instr_Done),  32'(e.done));
            check("Illegal_Op",  32'(Illegal_Op),  32'(e.ill));
            check("Instr_Count", 32'(Instr_Count), 32'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [5:0] op;
      logic [5:0] legal_ops [6];
      int fs, ms, ab;
      legal_ops = '{O_R, O_LW, O_SW, O_BEQ, O_J, O_ADDI};

      RST = 1'b0; OP_Code = '0; Mem_Ready = 1'b1;
      @(posedge CLK); #1;
      repeat (3) step(1'b0, 6'($urandom), 1'b1, S_FETCH);

      run(O_LW, 0, 0);
      run(O_SW, 0, 2);
      run(O_R, 4, 0);
      run(O_BEQ, 0, 0);
      run(O_J, 0, 0);
      run(O_ADDI, 0, 0);
      run(6'b111111, 0, 0);

      build(O_LW, 0, 1);
      play(O_LW, 3);

      repeat (17) run(O_J, 0, 0);

      repeat (300) begin
         if ($urandom_range(0, 7) < 6) begin
            op = legal_ops[$urandom_range(0, 5)];
         end else begin
            do op = 6'($urandom); while (is_legal(op));
         end
         fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         build(op, fs, ms);
         ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, plan.size() - 1) : -1;
         play(op, ab);
      end

      @(negedge CLK); #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
